// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destinations after ID and decides
// stall vs. forwarding for the instruction currently in ID.
module hazard_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int STAGES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [ADDR_W-1:0]        id_src1,
  input  logic [ADDR_W-1:0]        id_src2,
  input  logic                     id_two_src,
  input  logic                     id_wb_en,
  input  logic                     id_mem_r_en,
  input  logic [ADDR_W-1:0]        id_dest,
  input  logic [DATA_W-1:0]        id_val1,
  input  logic [DATA_W-1:0]        id_val2,
  input  logic                     flush,
  input  logic                     fwd_en,
  input  logic [STAGES*DATA_W-1:0] stage_result,
  output logic                     stall,
  output logic [3:0]               fwd_sel1,
  output logic [3:0]               fwd_sel2,
  output logic [DATA_W-1:0]        op_val1,
  output logic [DATA_W-1:0]        op_val2,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              fwd_cnt
);

  typedef struct packed {
    logic              valid;
    logic              wbEn;
    logic              memR;
    logic [ADDR_W-1:0] dest;
  } entry_t;

  entry_t      entry_q [STAGES];
  entry_t      entry_d [STAGES];
  logic [31:0] stallCnt_q, stallCnt_d;
  logic [31:0] fwdCnt_q, fwdCnt_d;
  logic [STAGES-1:0] match1, match2;
  logic        admit;

  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 0; k < STAGES; k++) begin
      match1[k] = id_valid && entry_q[k].valid && entry_q[k].wbEn &&
                  (entry_q[k].dest == id_src1);
      match2[k] = id_valid && id_two_src && entry_q[k].valid && entry_q[k].wbEn &&
                  (entry_q[k].dest == id_src2);
    end
  end

  // The WB entry never stalls in stall-only mode: the register file writes through.
  always_comb begin
    stall = 1'b0;
    if (fwd_en) begin
      stall = (match1[0] || match2[0]) && entry_q[0].memR;
    end else begin
      stall = |(match1[STAGES-2:0] | match2[STAGES-2:0]);
    end
  end

  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    op_val1  = id_val1;
    op_val2  = id_val2;
    if (fwd_en && !stall) begin
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (match1[k]) begin
          fwd_sel1 = 4'(k + 1);
          op_val1  = stage_result[k*DATA_W +: DATA_W];
        end
        if (match2[k]) begin
          fwd_sel2 = 4'(k + 1);
          op_val2  = stage_result[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    admit = !stall && !flush;
    for (int k = 1; k < STAGES; k++) begin
      entry_d[k] = entry_q[k-1];
    end
    entry_d[0] = '0;
    if (admit) begin
      entry_d[0] = '{valid: id_valid, wbEn: id_wb_en, memR: id_mem_r_en, dest: id_dest};
    end

    stallCnt_d = stallCnt_q;
    if (stall && !flush && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
    fwdCnt_d = fwdCnt_q;
    if (admit && ((fwd_sel1 != 4'd0) || (fwd_sel2 != 4'd0)) && (fwdCnt_q != 32'hFFFF_FFFF)) begin
      fwdCnt_d = fwdCnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        entry_q[k] <= '0;
      end
      stallCnt_q <= '0;
      fwdCnt_q   <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        entry_q[k] <= entry_d[k];
      end
      stallCnt_q <= stallCnt_d;
      fwdCnt_q   <= fwdCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;
  assign fwd_cnt   = fwdCnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios followed by
// randomized traffic, all compared against an in-flight instruction list model.
module tb_hazard_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int STAGES = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     id_valid = 1'b0;
  logic [ADDR_W-1:0]        id_src1 = '0, id_src2 = '0, id_dest = '0;
  logic                     id_two_src = 1'b0, id_wb_en = 1'b0, id_mem_r_en = 1'b0;
  logic [DATA_W-1:0]        id_val1 = '0, id_val2 = '0;
  logic                     flush = 1'b0, fwd_en = 1'b0;
  logic [STAGES*DATA_W-1:0] stage_result = '0;
  logic                     stall;
  logic [3:0]               fwd_sel1, fwd_sel2;
  logic [DATA_W-1:0]        op_val1, op_val2;
  logic [31:0]              stall_cnt, fwd_cnt;

  hazard_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .id_val1(id_val1), .id_val2(id_val2), .flush(flush),
    .fwd_en(fwd_en), .stage_result(stage_result), .stall(stall), .fwd_sel1(fwd_sel1),
    .fwd_sel2(fwd_sel2), .op_val1(op_val1), .op_val2(op_val2), .stall_cnt(stall_cnt),
    .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    bit wb;
    bit mr;
    int dest;
  } instr_t;

  instr_t      pipe [STAGES];
  int unsigned mStallCnt = 0, mFwdCnt = 0;
  bit          eStall;
  int          eSel1, eSel2;
  logic [31:0] eOp1, eOp2;
  int          checkCount = 0, failCount = 0;
  int unsigned savedStallCnt;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Index of the youngest in-flight writer of src, or -1 when none.
  function automatic int youngest(input int src, input bit used);
    if (!id_valid || !used) return -1;
    for (int k = 0; k < STAGES; k++) begin
      if (pipe[k].v && pipe[k].wb && pipe[k].dest == src) return k;
    end
    return -1;
  endfunction

  task automatic computeExpected();
    int y1, y2;
    y1 = youngest(int'(id_src1), 1'b1);
    y2 = youngest(int'(id_src2), id_two_src);
    if (fwd_en) eStall = (y1 == 0 || y2 == 0) && pipe[0].mr;
    else        eStall = (y1 >= 0 && y1 < STAGES - 1) || (y2 >= 0 && y2 < STAGES - 1);
    eSel1 = (fwd_en && !eStall && y1 >= 0) ? y1 + 1 : 0;
    eSel2 = (fwd_en && !eStall && y2 >= 0) ? y2 + 1 : 0;
    eOp1  = (eSel1 != 0) ? stage_result[(eSel1-1)*DATA_W +: DATA_W] : id_val1;
    eOp2  = (eSel2 != 0) ? stage_result[(eSel2-1)*DATA_W +: DATA_W] : id_val2;
  endtask

  task automatic checkAll();
    computeExpected();
    checkOutput("stall", 64'(stall), 64'(eStall));
    checkOutput("fwd_sel1", 64'(fwd_sel1), 64'(eSel1));
    checkOutput("fwd_sel2", 64'(fwd_sel2), 64'(eSel2));
    checkOutput("op_val1", 64'(op_val1), 64'(eOp1));
    checkOutput("op_val2", 64'(op_val2), 64'(eOp2));
    checkOutput("stall_cnt", 64'(stall_cnt), 64'(mStallCnt));
    checkOutput("fwd_cnt", 64'(fwd_cnt), 64'(mFwdCnt));
  endtask

  task automatic modelAdvance();
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) pipe[k] = '{0, 0, 0, 0};
      mStallCnt = 0;
      mFwdCnt   = 0;
    end else begin
      if (eStall && !flush && mStallCnt != 32'hFFFF_FFFF) mStallCnt++;
      if (!eStall && !flush && (eSel1 != 0 || eSel2 != 0) && mFwdCnt != 32'hFFFF_FFFF) mFwdCnt++;
      for (int k = STAGES - 1; k > 0; k--) pipe[k] = pipe[k-1];
      if (!eStall && !flush) pipe[0] = '{id_valid, id_wb_en, id_mem_r_en, int'(id_dest)};
      else                   pipe[0] = '{0, 0, 0, 0};
    end
  endtask

  task automatic runCycle();
    checkAll();
    modelAdvance();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input int s1, input int s2, input bit two,
                               input bit wb, input bit mr, input int dest,
                               input bit fl, input bit fe);
    id_valid     = v;
    id_src1      = ADDR_W'(s1);
    id_src2      = ADDR_W'(s2);
    id_two_src   = two;
    id_wb_en     = wb;
    id_mem_r_en  = mr;
    id_dest      = ADDR_W'(dest);
    flush        = fl;
    fwd_en       = fe;
    id_val1      = $urandom;
    id_val2      = $urandom;
    stage_result = {$urandom, $urandom, $urandom};
    #4;
  endtask

  task automatic idle(input int n, input bit fe);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, fe);
      runCycle();
    end
  endtask

  initial begin
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(2, 0);
    checkOutput("reset_stall", 64'(stall), 64'd0);
    rst = 1'b1;

    // Stall-only: RAW on r3 stalls for two cycles, then WB write-through resolves it.
    applyStimulus(1, 0, 0, 0, 1, 0, 3, 0, 0); runCycle();
    applyStimulus(1, 3, 0, 0, 1, 0, 9, 0, 0);
    checkOutput("so_stall_a", 64'(stall), 64'd1); runCycle();
    applyStimulus(1, 3, 0, 0, 1, 0, 9, 0, 0);
    checkOutput("so_stall_b", 64'(stall), 64'd1); runCycle();
    applyStimulus(1, 3, 0, 0, 1, 0, 9, 0, 0);
    checkOutput("so_stall_c", 64'(stall), 64'd0);
    checkOutput("so_cnt", 64'(stall_cnt), 64'd2); runCycle();
    idle(3, 0);

    // Forwarding from EXE on both operands.
    applyStimulus(1, 0, 0, 0, 1, 0, 5, 0, 1); runCycle();
    applyStimulus(1, 5, 5, 1, 0, 0, 0, 0, 1);
    checkOutput("fw_stall", 64'(stall), 64'd0);
    checkOutput("fw_sel1", 64'(fwd_sel1), 64'd1);
    checkOutput("fw_sel2", 64'(fwd_sel2), 64'd1);
    checkOutput("fw_op1", 64'(op_val1), 64'(stage_result[31:0])); runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("fw_cnt", 64'(fwd_cnt), 64'd1); runCycle();
    idle(3, 1);

    // Load-use: one stall, then forward from MEM.
    applyStimulus(1, 0, 0, 0, 1, 1, 2, 0, 1); runCycle();
    applyStimulus(1, 0, 2, 1, 0, 0, 0, 0, 1);
    checkOutput("lu_stall", 64'(stall), 64'd1); runCycle();
    applyStimulus(1, 0, 2, 1, 0, 0, 0, 0, 1);
    checkOutput("lu_stall_clear", 64'(stall), 64'd0);
    checkOutput("lu_sel2", 64'(fwd_sel2), 64'd2); runCycle();
    idle(3, 1);

    // Youngest writer of r7 wins.
    applyStimulus(1, 0, 0, 0, 1, 0, 7, 0, 1); runCycle();
    applyStimulus(1, 0, 0, 0, 1, 0, 7, 0, 1); runCycle();
    applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("yp_sel1", 64'(fwd_sel1), 64'd1); runCycle();
    idle(3, 1);

    // Flushed writer of r4 leaves no hazard behind.
    savedStallCnt = mStallCnt;
    applyStimulus(1, 0, 0, 0, 1, 0, 4, 1, 1); runCycle();
    applyStimulus(1, 4, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("fl_stall", 64'(stall), 64'd0);
    checkOutput("fl_sel1", 64'(fwd_sel1), 64'd0);
    checkOutput("fl_cnt", 64'(stall_cnt), 64'(savedStallCnt)); runCycle();
    idle(3, 0);

    // Reset while stalled forgets the hazard and the counters.
    applyStimulus(1, 0, 0, 0, 1, 0, 6, 0, 0); runCycle();
    applyStimulus(1, 6, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rs_stall_before", 64'(stall), 64'd1);
    rst = 1'b0; runCycle();
    rst = 1'b1;
    applyStimulus(1, 6, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rs_stall_after", 64'(stall), 64'd0);
    checkOutput("rs_stall_cnt", 64'(stall_cnt), 64'd0);
    checkOutput("rs_fwd_cnt", 64'(fwd_cnt), 64'd0); runCycle();

    // Randomized traffic over a small register range to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
                    $urandom_range(0, 3), $urandom_range(0, 9) == 0, ((i / 50) % 2) == 1);
      runCycle();
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", checkCount, failCount);
    $finish;
  end

endmodule
